envelope_vca: RTL

//  Voltage-controlled amplifier stage that sits after the envelope generator.
//  On each sample_clock rising edge it latches one signed oscillator sample and
//  the envelope's 8-bit volume. It then scales the sample using a serial

---
 rtl/envelope_vca.sv | 97 +++++++++
 1 files changed

// File: rtl/envelope_vca.sv
// Per-channel VCA: scales a latched signed sample by an 8-bit envelope volume
// using a serial shift-add multiplier. Optional macro VCA_UNITY_EN: volume all-ones passes the sample unchanged.
module envelope_vca #(
    parameter int BITDEPTH = 14,
    parameter int VOLBITS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_clock,
    input  logic signed [BITDEPTH-1:0] sample_in,
    input  logic        [VOLBITS-1:0]  volume,
    output logic signed [BITDEPTH-1:0] sample_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACCW = BITDEPTH + VOLBITS;
    localparam int CW   = (VOLBITS > 1) ? $clog2(VOLBITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t                     r_state;
    logic                       r_sc_q;
    logic signed [BITDEPTH-1:0] r_s;
    logic        [VOLBITS-1:0]  r_v;
    logic signed [ACCW-1:0]     r_acc;
    logic        [CW-1:0]       r_cnt;

    logic                       w_edge;
    logic signed [ACCW-1:0]     w_sext;
    logic signed [ACCW-1:0]     w_addend;
    logic signed [BITDEPTH-1:0] w_result;

    assign w_edge   = sample_clock & ~r_sc_q;
    assign w_sext   = {{VOLBITS{r_s[BITDEPTH-1]}}, r_s};
    assign w_addend = w_sext << r_cnt;

    // Upper BITDEPTH bits of the accumulator are the floor of acc / 2^VOLBITS.
`ifdef VCA_UNITY_EN
    assign w_result = (r_v == '1) ? r_s : r_acc[ACCW-1:VOLBITS];
`else
    assign w_result = r_acc[ACCW-1:VOLBITS];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sc_q     <= 1'b1;
            r_s        <= '0;
            r_v        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_sc_q    <= sample_clock;
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_s     <= sample_in;
                        r_v     <= volume;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_edge) overrun <= 1'b1;
                    if (r_v[r_cnt]) r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(VOLBITS - 1)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (w_edge) overrun <= 1'b1;
                    sample_out <= w_result;
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
